// File: rtl/jtdd_objbuf_if.sv
// Object line buffer bus: timing-generator and draw-engine inputs, mixer-facing outputs.
interface jtdd_objbuf_if;
   logic       pxl_cen;
   logic       HBL;
   logic [7:0] HPOS;
   logic       flip;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       swap;
   logic       init;
   logic [7:0] obj_pxl;

   modport master (
      output pxl_cen, HBL, HPOS, flip, wr_en, wr_addr, wr_data,
      input  swap, init, obj_pxl
   );

   modport slave (
      input  pxl_cen, HBL, HPOS, flip, wr_en, wr_addr, wr_data,
      output swap, init, obj_pxl
   );
endinterface

// File: rtl/jtdd_objbuf.sv
// Double-buffered object line buffer: draw engine fills one bank while the other is read and cleared.
// Pixel out one pxl_cen after HPOS; writes accepted every clk with no backpressure.
module jtdd_objbuf #(
   parameter logic [3:0] TRANSP = 4'hF,
   parameter logic [7:0] CLRVAL = 8'hFF
) (
   input  logic         clk,
   input  logic         rst,
   jtdd_objbuf_if.slave bus
);
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [8:0] r_cnt;
   logic       r_bank;
   logic       r_hbl_l;
   logic       r_swap;
   logic       r_clr_vld;
   logic [7:0] r_clr_addr;
   logic [7:0] r_pxl;
   logic [7:0] r_mem [512];

   logic       w_init;
   logic       w_rd;
   logic       w_blank;
   logic       w_swap_ev;
   logic       w_wr;
   logic [8:0] w_wr_addr;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_init      = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_init = 1'b1;
            if (r_cnt == 9'd511) w_state_nxt = ST_RUN;
         end
         ST_RUN: ;
      endcase
   end

   assign w_rd      = ~w_init & bus.pxl_cen & ~bus.HBL;
   assign w_blank   = ~w_init & bus.pxl_cen &  bus.HBL;
   assign w_swap_ev = w_blank & ~r_hbl_l;
   assign w_wr      = ~w_init & bus.wr_en & ~bus.wr_addr[8] & (bus.wr_data[3:0] != TRANSP);
   // Writes always target the bank not being displayed, before any toggle this clk
   assign w_wr_addr = {~r_bank, bus.wr_addr[7:0] ^ {8{bus.flip}}};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 9'd0;
         r_bank     <= 1'b0;
         r_hbl_l    <= 1'b1;
         r_swap     <= 1'b0;
         r_clr_vld  <= 1'b0;
         r_clr_addr <= 8'd0;
         r_pxl      <= CLRVAL;
      end else begin
         if (w_init) r_cnt <= r_cnt + 9'd1;
         if (bus.pxl_cen) r_hbl_l <= bus.HBL;
         r_swap    <= w_swap_ev;
         if (w_swap_ev) r_bank <= ~r_bank;
         r_clr_vld <= w_rd;
         if (w_rd) r_clr_addr <= bus.HPOS;
         if (w_rd)         r_pxl <= r_mem[{r_bank, bus.HPOS}];
         else if (w_blank) r_pxl <= CLRVAL;
      end
   end

   // Clear and draw writes land in opposite banks, so both may fire in one clk
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_init) begin
            r_mem[r_cnt] <= CLRVAL;
         end else begin
            if (r_clr_vld) r_mem[{r_bank, r_clr_addr}] <= CLRVAL;
            if (w_wr)      r_mem[w_wr_addr] <= bus.wr_data;
         end
      end
   end

   assign bus.swap    = r_swap;
   assign bus.init    = w_init;
   assign bus.obj_pxl = r_pxl;
endmodule

// File: tb/tb_jtdd_objbuf.sv
// Randomised bench for jtdd_objbuf against a pixel-level two-bank reference model.
module tb_jtdd_objbuf;
   logic clk = 1'b0;
   logic rst = 1'b1;
   jtdd_objbuf_if bus ();

   jtdd_objbuf dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [7:0] m_mem [2][256];
   bit         m_bank;
   bit         m_hbl_l;
   bit         m_run = 1'b0;
   logic [7:0] exp_pxl;
   int         exp_swaps = 0;
   int         swap_seen = 0;

   logic [255:0][7:0] obs_line, exp_line;
   logic [127:0][7:0] obs_blk;

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++) m_mem[b][i] = 8'hFF;
      m_bank  = 1'b0;
      m_hbl_l = 1'b1;
      exp_pxl = 8'hFF;
   endtask

   function automatic int first_diff(input logic [255:0][7:0] a, input logic [255:0][7:0] b);
      for (int i = 0; i < 256; i++) if (a[i] !== b[i]) return i;
      return 0;
   endfunction

   // One clk: drive at negedge, update model at the edge, return at next negedge
   task automatic drive(input logic cen, input logic hbl, input logic [7:0] hpos,
                        input logic we, input logic [8:0] waddr, input logic [7:0] wdata);
      bus.pxl_cen = cen;
      bus.HBL     = hbl;
      bus.HPOS    = hpos;
      bus.wr_en   = we;
      bus.wr_addr = waddr;
      bus.wr_data = wdata;
      @(posedge clk);
      if (m_run && !rst) begin
         if (we && !waddr[8] && wdata[3:0] != 4'hF)
            m_mem[~m_bank][waddr[7:0] ^ {8{bus.flip}}] = wdata;
         if (cen) begin
            if (hbl) begin
               exp_pxl = 8'hFF;
               if (!m_hbl_l) begin
                  m_bank = ~m_bank;
                  exp_swaps++;
               end
            end else begin
               exp_pxl = m_mem[m_bank][hpos];
               m_mem[m_bank][hpos] = 8'hFF;
            end
            m_hbl_l = hbl;
         end
      end
      @(negedge clk);
      if (bus.swap === 1'b1) swap_seen++;
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      drive(1'b0, 1'b1, 8'($urandom), 1'b1, a, d);
   endtask

   task automatic do_line(input bit rnd);
      logic we;
      for (int h = 0; h < 256; h++) begin
         we = rnd && ($urandom_range(0, 2) == 0);
         drive(1'b1, 1'b0, 8'(h), we, 9'($urandom), 8'($urandom));
         obs_line[h] = bus.obj_pxl;
         exp_line[h] = exp_pxl;
         we = rnd && ($urandom_range(0, 2) == 0);
         drive(1'b0, 1'b0, 8'(h), we, 9'($urandom), 8'($urandom));
      end
   endtask

   task automatic blank(input int n, input logic we0, input logic [8:0] a0, input logic [7:0] d0);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 1'b1, 8'($urandom), we0 && (i == 0), a0, d0);
         if (i < 128) obs_blk[i] = bus.obj_pxl;
         drive(1'b0, 1'b1, 8'($urandom), 1'b0, 9'd0, 8'd0);
      end
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      int bad = 0;
      int s0 = swap_seen;
      while (bus.init === 1'b1 && n < 600) begin
         if (bus.obj_pxl !== 8'hFF) bad++;
         drive(n[0] == 1'b0, 1'b1, 8'($urandom), 1'($urandom), 9'($urandom), 8'($urandom));
         n++;
      end
      n_checks++;
      if (n != 512) begin n_fail++; $display("FAIL %s_init_len: got %0d clks required 512", tag, n); end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL %s_init_pxl: %0d non-FF samples, required 0", tag, bad); end
      n_checks++;
      if (swap_seen != s0) begin n_fail++; $display("FAIL %s_init_swap: got %0d swaps required 0", tag, swap_seen - s0); end
   endtask

   task automatic test_reset();
      int s0, e0, h;
      rst = 1'b1;
      repeat (4) drive(1'($urandom), 1'b1, 8'($urandom), 1'($urandom), 9'($urandom), 8'($urandom));
      n_checks++;
      if (bus.obj_pxl !== 8'hFF) begin n_fail++; $display("FAIL reset_pxl: got %h required ff", bus.obj_pxl); end
      n_checks++;
      if (bus.init !== 1'b1) begin n_fail++; $display("FAIL reset_init: got %b required 1", bus.init); end
      n_checks++;
      if (bus.swap !== 1'b0) begin n_fail++; $display("FAIL reset_swap: got %b required 0", bus.swap); end
      rst = 1'b0;
      wait_init("reset");
      model_reset();
      m_run = 1'b1;
      do_line(1'b0);
      n_checks++;
      if (obs_line !== exp_line) begin
         n_fail++; h = first_diff(obs_line, exp_line);
         $display("FAIL reset_bank0: HPOS %0d got %h required %h", h, obs_line[h], exp_line[h]);
      end
      s0 = swap_seen; e0 = exp_swaps;
      blank(8, 1'b0, 9'd0, 8'd0);
      n_checks++;
      if (swap_seen - s0 != 1 || exp_swaps - e0 != 1) begin
         n_fail++; $display("FAIL reset_first_swap: got %0d swaps required 1", swap_seen - s0);
      end
      do_line(1'b0);
      n_checks++;
      if (obs_line !== exp_line) begin
         n_fail++; h = first_diff(obs_line, exp_line);
         $display("FAIL reset_bank1: HPOS %0d got %h required %h", h, obs_line[h], exp_line[h]);
      end
   endtask

   task automatic test_basic();
      int h;
      bus.flip = 1'b0;
      wr(9'd10, 8'h35);
      blank(8, 1'b0, 9'd0, 8'd0);
      do_line(1'b0);
      n_checks++;
      if (obs_line[10] !== 8'h35) begin n_fail++; $display("FAIL basic_hpos10: got %h required 35", obs_line[10]); end
      n_checks++;
      if (obs_line !== exp_line) begin
         n_fail++; h = first_diff(obs_line, exp_line);
         $display("FAIL basic_line: HPOS %0d got %h required %h", h, obs_line[h], exp_line[h]);
      end
      blank(8, 1'b0, 9'd0, 8'd0);
      do_line(1'b0);
      blank(8, 1'b0, 9'd0, 8'd0);
      do_line(1'b0);
      n_checks++;
      if (obs_line[10] !== 8'hFF) begin n_fail++; $display("FAIL basic_cleared: got %h required ff", obs_line[10]); end
   endtask

   task automatic test_flip();
      int h;
      bus.flip = 1'b1;
      wr(9'd10, 8'h52);
      bus.flip = 1'b0;
      blank(8, 1'b0, 9'd0, 8'd0);
      do_line(1'b0);
      n_checks++;
      if (obs_line[245] !== 8'h52) begin n_fail++; $display("FAIL flip_hpos245: got %h required 52", obs_line[245]); end
      n_checks++;
      if (obs_line !== exp_line) begin
         n_fail++; h = first_diff(obs_line, exp_line);
         $display("FAIL flip_line: HPOS %0d got %h required %h", h, obs_line[h], exp_line[h]);
      end
   endtask

   task automatic test_discard();
      int h;
      wr(9'd30, 8'h4F);
      wr(9'd300, 8'h35);
      wr(9'd20, 8'h11);
      wr(9'd20, 8'h22);
      blank(8, 1'b0, 9'd0, 8'd0);
      do_line(1'b0);
      n_checks++;
      if (obs_line[30] !== 8'hFF || obs_line[44] !== 8'hFF) begin
         n_fail++; $display("FAIL discard: HPOS30 %h HPOS44 %h required ff ff", obs_line[30], obs_line[44]);
      end
      n_checks++;
      if (obs_line[20] !== 8'h22) begin n_fail++; $display("FAIL overwrite: got %h required 22", obs_line[20]); end
      n_checks++;
      if (obs_line !== exp_line) begin
         n_fail++; h = first_diff(obs_line, exp_line);
         $display("FAIL discard_line: HPOS %0d got %h required %h", h, obs_line[h], exp_line[h]);
      end
   endtask

   task automatic test_hbl();
      int s0 = swap_seen;
      blank(128, 1'b1, 9'd77, 8'hA6);
      n_checks++;
      if (swap_seen - s0 != 1) begin n_fail++; $display("FAIL hbl_swap_pulse: got %0d swap clks required 1", swap_seen - s0); end
      n_checks++;
      if (obs_blk !== {128{8'hFF}}) begin n_fail++; $display("FAIL hbl_blank_pxl: non-ff pixel during blank"); end
      do_line(1'b0);
      n_checks++;
      if (obs_line[77] !== 8'hA6) begin n_fail++; $display("FAIL swap_clk_write: got %h required a6", obs_line[77]); end
   endtask

   task automatic test_random();
      int h, s0, e0;
      for (int l = 0; l < 8; l++) begin
         bus.flip = 1'($urandom);
         s0 = swap_seen; e0 = exp_swaps;
         blank($urandom_range(2, 20), 1'($urandom), 9'($urandom), 8'($urandom));
         do_line(1'b1);
         n_checks++;
         if (swap_seen - s0 != exp_swaps - e0) begin
            n_fail++; $display("FAIL random_swaps line %0d: got %0d required %0d", l, swap_seen - s0, exp_swaps - e0);
         end
         n_checks++;
         if (obs_line !== exp_line) begin
            n_fail++; h = first_diff(obs_line, exp_line);
            $display("FAIL random_line %0d: HPOS %0d got %h required %h", l, h, obs_line[h], exp_line[h]);
         end
      end
      bus.flip = 1'b0;
   endtask

   task automatic test_midline_reset();
      int h, s0;
      wr(9'd100, 8'h5A);
      wr(9'd50, 8'h77);
      blank(8, 1'b0, 9'd0, 8'd0);
      for (int i = 0; i <= 100; i++) begin
         drive(1'b1, 1'b0, 8'(i), 1'b0, 9'd0, 8'd0);
         drive(1'b0, 1'b0, 8'(i), 1'b0, 9'd0, 8'd0);
      end
      n_checks++;
      if (bus.obj_pxl !== 8'h5A) begin n_fail++; $display("FAIL midline_pre: got %h required 5a", bus.obj_pxl); end
      m_run = 1'b0;
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'd101, 1'b0, 9'd0, 8'd0);
      n_checks++;
      if (bus.obj_pxl !== 8'hFF || bus.init !== 1'b1) begin
         n_fail++; $display("FAIL midline_rst: pxl %h init %b required ff 1", bus.obj_pxl, bus.init);
      end
      drive(1'b0, 1'b1, 8'd0, 1'b0, 9'd0, 8'd0);
      rst = 1'b0;
      wait_init("midline");
      model_reset();
      m_run = 1'b1;
      s0 = swap_seen;
      blank(4, 1'b0, 9'd0, 8'd0);
      n_checks++;
      if (swap_seen != s0) begin n_fail++; $display("FAIL midline_noswap: got %0d swaps required 0", swap_seen - s0); end
      do_line(1'b0);
      blank(8, 1'b0, 9'd0, 8'd0);
      do_line(1'b0);
      n_checks++;
      if (obs_line !== exp_line) begin
         n_fail++; h = first_diff(obs_line, exp_line);
         $display("FAIL midline_clear: HPOS %0d got %h required %h", h, obs_line[h], exp_line[h]);
      end
   endtask

   initial begin
      bus.pxl_cen = 1'b0; bus.HBL = 1'b1; bus.HPOS = 8'd0; bus.flip = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = 9'd0; bus.wr_data = 8'd0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_flip();
      test_discard();
      test_hbl();
      test_random();
      test_midline_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
